multdiv_unit: RTL and testbench
===============================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 Parameters SHALL be, one per line: WIDTH, 32, operand/result width in bits (>=4); TAG_W, 5, width of the destination-register tag carried with each operation.
REQ-002 clock  input  1  master clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; accepted only when busy=0.
REQ-005 op_div  input  1  1 = divide, 0 = multiply; sampled with start.
REQ-006 operand_a  input  WIDTH  multiplicand/dividend, two's complement.
REQ-007 operand_b  input  WIDTH  multiplier/divisor, two's complement.
REQ-008 tag_in  input  TAG_W  destination tag, sampled with start.
REQ-009 flush  input  1  abort any in-flight operation.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.
REQ-011 result_valid  output  1  single-cycle pulse, result fields valid.
REQ-012 result  output  WIDTH  product low WIDTH bits or quotient.
REQ-013 exception  output  1  mult overflow, divide-by-zero, or MIN/-1; valid with result_valid.
REQ-014 tag_out  output  TAG_W  tag latched at accept, valid with result_valid.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; IDLE->BUSY on accepted start; BUSY->DONE after WIDTH iteration cycles; DONE->IDLE unconditionally next cycle.
REQ-016 Start SHALL be accepted only in IDLE; start while busy=1 SHALL be ignored with no effect on in-flight state.
REQ-017 Operands, op_div and tag_in SHALL be registered at accept; later input changes SHALL NOT affect the operation.
REQ-018 Multiply SHALL use iterative shift-add on operand magnitudes, one bit per cycle, with sign fixup in DONE.
REQ-019 Divide SHALL use restoring division on magnitudes, one quotient bit per cycle; quotient truncated toward zero; remainder discarded.
REQ-020 result_valid SHALL assert exactly WIDTH+1 cycles after the accept edge (full-latency path) for exactly one cycle, in DONE.
REQ-021 Multiply exception SHALL assert when the true signed 2*WIDTH product does not fit in WIDTH signed bits; result = low WIDTH bits.
REQ-022 Divide by zero SHALL give result 0, exception 1.
REQ-023 Most-negative / -1 SHALL give result = most-negative value, exception 1.
REQ-024 result, exception, tag_out SHALL hold their DONE values until the next DONE; result_valid SHALL be 0 outside DONE.
REQ-025 flush SHALL force IDLE on the next edge from any state, suppress result_valid that cycle, and take priority over start.
REQ-026 flush and start in the same cycle in IDLE SHALL leave the unit IDLE (start dropped).

Reset
REQ-027 reset SHALL override flush and start and force IDLE; busy, result_valid, exception = 0; result, tag_out = 0; iteration counter = 0.
REQ-028 reset during BUSY or DONE SHALL discard the operation with no result_valid pulse.

Configuration
REQ-029 Macro MULTDIV_EARLY_OUT_EN defined: multiply with either operand 0, or divide with divisor 0, SHALL go IDLE->DONE directly; result_valid 1 cycle after accept.
REQ-030 Macro undefined: these cases SHALL take the full WIDTH+1 latency; result and exception values identical in both builds.

Structure
REQ-031 FSM state encoding and the exception-cause constants SHALL live in shared package multdiv_pkg.
REQ-032 Magnitude/sign-fixup logic SHALL be one sub-module, multdiv_sign_fix, instantiated for operands and result; iteration datapath stays in multdiv_unit.

Verification (WIDTH=32, TAG_W=5)
REQ-033 mult 7 * -3, tag 9 -> result_valid at accept+33, result -21, exception 0, tag_out 9.
REQ-034 mult 0x7FFFFFFF * 2 -> result 0xFFFFFFFE, exception 1; div -7 / 2 -> result -3, exception 0.
REQ-035 div 5 / 0 -> result 0, exception 1; valid at accept+1 with MULTDIV_EARLY_OUT_EN, accept+33 without.
REQ-036 div 0x80000000 / -1 -> result 0x80000000, exception 1.
REQ-037 start 6*6 then second start at accept+5 -> only one result (36), second ignored; flush at accept+10 of a new op -> busy=0 next cycle, no result_valid.
REQ-038 reset at accept+12 of div 100/7 -> IDLE next cycle, all outputs 0, no result_valid; fresh 100/7 afterward -> 14.

Source files
------------

// File: rtl/multdiv_pkg.sv
// ----------------------------------------------------------------------------
// multdiv_pkg
//   Shared definitions for the iterative multiply/divide unit:
//     state_t      - FSM state encoding (IDLE, BUSY, DONE)
//     exc_cause_t  - reason a result carries the exception flag
//     is_exception - collapses a cause into the single exception output bit
// ----------------------------------------------------------------------------
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MUL_OVF  = 2'd1,  // signed product does not fit in WIDTH bits
    EXC_DIV_ZERO = 2'd2,  // divisor was zero
    EXC_DIV_OVF  = 2'd3   // most-negative / -1
  } exc_cause_t;

  function automatic logic is_exception(input exc_cause_t cause);
    return cause != EXC_NONE;
  endfunction

endpackage

// File: rtl/multdiv_sign_fix.sv
// ----------------------------------------------------------------------------
// multdiv_sign_fix
//   Conditional two's-complement negation. Used both to take operand
//   magnitudes (negate = operand sign bit) and to restore the sign of the
//   unsigned product/quotient (negate = sign_a ^ sign_b).
//   The magnitude of the most-negative value comes out as 2**(W-1), which is
//   the correct unsigned magnitude.
//
// Ports
//   value  in  W  input word
//   negate in  1  1 = output the two's-complement negation of value
//   fixed  out W  value or -value
// ----------------------------------------------------------------------------
module multdiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] fixed
);

  assign fixed = negate ? ((~value) + W'(1)) : value;

endmodule

// File: rtl/multdiv_unit.sv
// ----------------------------------------------------------------------------
// multdiv_unit
//   Iterative signed multiply / divide. One accepted operation at a time;
//   multiply is shift-add on magnitudes, divide is restoring division on
//   magnitudes, one bit per cycle, with the sign restored on the way into DONE.
//
//   Latency: result_valid is visible in the cycle WIDTH+1 cycles after the
//   cycle in which start was accepted (WIDTH iteration edges, the last of
//   which enters DONE with the sign-fixed result).
//
// Configuration
//   MULTDIV_EARLY_OUT_EN  when defined, multiply with a zero operand or divide
//                         by zero skips the iteration and goes IDLE->DONE on
//                         the accept edge. Result/exception values are the
//                         same in both builds.
//
// Ports
//   clock        in   1      rising-edge clock
//   reset        in   1      synchronous active-high reset
//   start        in   1      request; accepted only while IDLE
//   op_div       in   1      1 = divide, 0 = multiply
//   operand_a    in   WIDTH  multiplicand / dividend (signed)
//   operand_b    in   WIDTH  multiplier / divisor (signed)
//   tag_in       in   TAG_W  destination tag
//   flush        in   1      abort any in-flight operation
//   busy         out  1      FSM not IDLE
//   result_valid out  1      one-cycle pulse in DONE
//   result       out  WIDTH  product low bits or quotient
//   exception    out  1      overflow / divide-by-zero / MIN/-1
//   tag_out      out  TAG_W  tag captured at accept
// ----------------------------------------------------------------------------
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [TAG_W-1:0] tag_out
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_IT  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State and operation registers
  // --------------------------------------------------------------------------
  state_t           state;
  logic [CNT_W-1:0] iter_cnt;
  logic [WIDTH-1:0] mag_a;       // multiplicand magnitude (multiply addend)
  logic [WIDTH-1:0] mag_b;       // divisor magnitude
  logic [WIDTH-1:0] acc_hi;      // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;      // multiplier shifted out / dividend->quotient
  logic             op_div_q;
  logic             neg_q;       // final result must be negated
  logic             div_zero_q;
  logic             div_ovf_q;
  logic [TAG_W-1:0] tag_q;

  // --------------------------------------------------------------------------
  // Operand magnitudes, taken from the raw inputs at accept
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;

  multdiv_sign_fix #(.W(WIDTH)) u_abs_a (
    .value  (operand_a),
    .negate (operand_a[WIDTH-1]),
    .fixed  (mag_a_in)
  );

  multdiv_sign_fix #(.W(WIDTH)) u_abs_b (
    .value  (operand_b),
    .negate (operand_b[WIDTH-1]),
    .fixed  (mag_b_in)
  );

  logic early_out;
  logic div_zero_in;
  logic div_ovf_in;

  assign div_zero_in = (operand_b == '0);
  assign div_ovf_in  = (operand_a == MOST_NEG) && (operand_b == '1);

`ifdef MULTDIV_EARLY_OUT_EN
  assign early_out = op_div ? div_zero_in
                            : ((operand_a == '0) || div_zero_in);
`else
  assign early_out = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // One iteration step (multiply or divide) on the accumulator pair
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_take;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] acc_hi_next;
  logic [WIDTH-1:0] acc_lo_next;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here via defaults at the top); a missed path would infer a latch.
  always_comb begin
    mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
    div_shift   = {acc_hi, acc_lo[WIDTH-1]};
    div_take    = (div_shift >= {1'b0, mag_b});
    div_rem     = WIDTH'(div_shift - {1'b0, mag_b});
    acc_hi_next = mul_sum[WIDTH:1];
    acc_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (op_div_q) begin
      // Restoring step: keep the trial subtraction only if it did not borrow.
      acc_hi_next = div_take ? div_rem : div_shift[WIDTH-1:0];
      acc_lo_next = {acc_lo[WIDTH-2:0], div_take};
    end
  end

  // --------------------------------------------------------------------------
  // Sign fixup of the final step's value, registered on the edge into DONE
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;

  multdiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .value  ({acc_hi_next, acc_lo_next}),
    .negate (neg_q),
    .fixed  (prod_fixed)
  );

  multdiv_sign_fix #(.W(WIDTH)) u_fix_quot (
    .value  (acc_lo_next),
    .negate (neg_q),
    .fixed  (quot_fixed)
  );

  exc_cause_t       cause;
  logic [WIDTH-1:0] final_result;
  logic             prod_hi_ones;
  logic             prod_hi_zeros;

  // The signed product fits in WIDTH bits only when its top WIDTH+1 bits are
  // a pure sign extension.
  assign prod_hi_ones  = &prod_fixed[2*WIDTH-1:WIDTH-1];
  assign prod_hi_zeros = ~|prod_fixed[2*WIDTH-1:WIDTH-1];

  always_comb begin
    cause        = EXC_NONE;
    final_result = prod_fixed[WIDTH-1:0];
    if (op_div_q) begin
      final_result = quot_fixed;
      if (div_zero_q) begin
        cause        = EXC_DIV_ZERO;
        final_result = '0;
      end else if (div_ovf_q) begin
        // Magnitude quotient 2**(WIDTH-1) with positive sign already wraps
        // to the most-negative pattern, which is the required result.
        cause = EXC_DIV_OVF;
      end
    end else if (!prod_hi_ones && !prod_hi_zeros) begin
      cause = EXC_MUL_OVF;
    end
  end

  exc_cause_t early_cause;
  assign early_cause = op_div ? EXC_DIV_ZERO : EXC_NONE;

  // --------------------------------------------------------------------------
  // FSM, datapath registers and registered outputs
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: only control state and outputs are reset; the operand and
  // accumulator registers are always loaded at accept before being read.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      iter_cnt     <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      exception    <= 1'b0;
      tag_out      <= '0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        state    <= ST_IDLE;
        iter_cnt <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              op_div_q   <= op_div;
              neg_q      <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
              div_zero_q <= div_zero_in;
              div_ovf_q  <= div_ovf_in;
              tag_q      <= tag_in;
              mag_a      <= mag_a_in;
              mag_b      <= mag_b_in;
              acc_hi     <= '0;
              acc_lo     <= op_div ? mag_a_in : mag_b_in;
              iter_cnt   <= '0;
              busy       <= 1'b1;
              if (early_out) begin
                state        <= ST_DONE;
                result       <= '0;
                exception    <= is_exception(early_cause);
                tag_out      <= tag_in;
                result_valid <= 1'b1;
              end else begin
                state <= ST_BUSY;
              end
            end
          end

          ST_BUSY: begin
            acc_hi   <= acc_hi_next;
            acc_lo   <= acc_lo_next;
            iter_cnt <= iter_cnt + 1'b1;
            if (iter_cnt == LAST_IT) begin
              state        <= ST_DONE;
              result       <= final_result;
              exception    <= is_exception(cause);
              tag_out      <= tag_q;
              result_valid <= 1'b1;
            end
          end

          ST_DONE: begin
            state    <= ST_IDLE;
            iter_cnt <= '0;
            busy     <= 1'b0;
          end

          default: begin
            state    <= ST_IDLE;
            iter_cnt <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// ----------------------------------------------------------------------------
// tb_multdiv_unit
//   Directed self-checking bench for multdiv_unit (WIDTH=32, TAG_W=5).
//   Cycle numbering: the cycle in which start is accepted is "accept"; the
//   cycle after the accept edge is accept+1. Outputs are sampled 1 ns after
//   each rising edge, inputs change at those same points.
// ----------------------------------------------------------------------------
module tb_multdiv_unit;

  localparam int WIDTH  = 32;
  localparam int TAG_W  = 5;
  localparam int FULL_LAT = WIDTH + 1;
`ifdef MULTDIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = WIDTH + 1;
`endif
  localparam int WINDOW = 40;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic [TAG_W-1:0] tag_out;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  multdiv_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .op_div       (op_div),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .tag_in       (tag_in),
    .flush        (flush),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .exception    (exception),
    .tag_out      (tag_out)
  );

  // Issue one operation and observe WINDOW cycles after accept. Inputs are
  // scrambled right after accept so a design that keeps sampling them fails.
  task automatic run_op(input logic div, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                        output int lat, output logic [WIDTH-1:0] res,
                        output logic exc, output logic [TAG_W-1:0] tg,
                        output int pulses);
    start = 1'b1; op_div = div; operand_a = a; operand_b = b; tag_in = tag;
    @(posedge clock); #1;
    start = 1'b0; op_div = ~div; operand_a = 32'h5A5A_A5A5; operand_b = 32'h0F0F_F0F1;
    tag_in = ~tag;
    lat = 0; pulses = 0; res = '0; exc = 1'b0; tg = '0;
    for (int cnt = 1; cnt <= WINDOW; cnt++) begin
      if (result_valid === 1'b1) begin
        if (pulses == 0) begin
          lat = cnt; res = result; exc = exception; tg = tag_out;
        end
        pulses++;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; flush = 1'b1; op_div = 1'b0;
    operand_a = 32'd3; operand_b = 32'd4; tag_in = 5'd1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (exception !== 1'b0) begin errors++; $display("FAIL reset_exception got=%b exp=0", exception); end
    checks++; if (tag_out !== 5'd0) begin errors++; $display("FAIL reset_tag got=%h exp=0", tag_out); end
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_mult_basic();
    int lat, pulses; logic [WIDTH-1:0] res; logic exc; logic [TAG_W-1:0] tg;
    run_op(1'b0, 32'd7, -32'sd3, 5'd9, lat, res, exc, tg, pulses);
    checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL mul7x-3_latency got=%0d exp=%0d", lat, FULL_LAT); end
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul7x-3_result got=%h exp=ffffffeb", res); end
    checks++; if (exc !== 1'b0) begin errors++; $display("FAIL mul7x-3_exception got=%b exp=0", exc); end
    checks++; if (tg !== 5'd9) begin errors++; $display("FAIL mul7x-3_tag got=%0d exp=9", tg); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL mul7x-3_pulses got=%0d exp=1", pulses); end
    // Outputs hold their DONE values while idle afterwards.
    checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul7x-3_hold got=%h exp=ffffffeb", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul7x-3_idle_busy got=%b exp=0", busy); end
  endtask

  typedef struct packed {
    logic             div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             exc;
    logic             early;
  } vec_t;

  task automatic test_vectors();
    vec_t vecs [8];
    int lat, pulses, exp_lat; logic [WIDTH-1:0] res; logic exc; logic [TAG_W-1:0] tg;
    vecs[0] = '{1'b0, 32'h7FFF_FFFF, 32'd2,        32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'd5,         32'd0,        32'd0,         1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'd0,         32'hFFFF_FFFD, 32'd0,         1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0,        1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'd20,       1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      exp_lat = vecs[i].early ? EARLY_LAT : FULL_LAT;
      run_op(vecs[i].div, vecs[i].a, vecs[i].b, TAG_W'(i + 3), lat, res, exc, tg, pulses);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
      checks++; if (res !== vecs[i].res) begin errors++; $display("FAIL vec%0d_result got=%h exp=%h", i, res, vecs[i].res); end
      checks++; if (exc !== vecs[i].exc) begin errors++; $display("FAIL vec%0d_exception got=%b exp=%b", i, exc, vecs[i].exc); end
      checks++; if (tg !== TAG_W'(i + 3)) begin errors++; $display("FAIL vec%0d_tag got=%0d exp=%0d", i, tg, i + 3); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL vec%0d_pulses got=%0d exp=1", i, pulses); end
    end
  endtask

  task automatic test_back_to_back();
    int lat = 0, pulses = 0; logic [WIDTH-1:0] res = '0;
    start = 1'b1; op_div = 1'b0; operand_a = 32'd6; operand_b = 32'd6; tag_in = 5'd2;
    @(posedge clock); #1;
    start = 1'b0;
    for (int cnt = 1; cnt <= WINDOW; cnt++) begin
      if (cnt == 5) begin
        start = 1'b1; operand_a = 32'd9; operand_b = 32'd9; tag_in = 5'd4;
      end else begin
        start = 1'b0;
      end
      if (result_valid === 1'b1) begin
        if (pulses == 0) begin lat = cnt; res = result; end
        pulses++;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
    checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, FULL_LAT); end
    checks++; if (res !== 32'd36) begin errors++; $display("FAIL b2b_result got=%0d exp=36", res); end
  endtask

  task automatic test_flush();
    int pulses = 0;
    start = 1'b1; op_div = 1'b0; operand_a = 32'd6; operand_b = 32'd6; tag_in = 5'd7;
    @(posedge clock); #1;
    start = 1'b0;
    for (int cnt = 1; cnt <= WINDOW; cnt++) begin
      if (cnt == 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
      end
      flush = (cnt == 10);
      if (result_valid === 1'b1) pulses++;
      @(posedge clock); #1;
    end
    flush = 1'b0;
    checks++; if (pulses != 0) begin errors++; $display("FAIL flush_pulses got=%0d exp=0", pulses); end

    // flush and start together while idle: start is dropped.
    pulses = 0;
    start = 1'b1; flush = 1'b1; operand_a = 32'd3; operand_b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got=%b exp=0", busy); end
    for (int cnt = 1; cnt <= WINDOW; cnt++) begin
      if (result_valid === 1'b1) pulses++;
      @(posedge clock); #1;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL flush_start_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0, lat; logic [WIDTH-1:0] res; logic exc; logic [TAG_W-1:0] tg;
    start = 1'b1; op_div = 1'b1; operand_a = 32'd100; operand_b = 32'd7; tag_in = 5'd12;
    @(posedge clock); #1;
    start = 1'b0;
    for (int cnt = 1; cnt <= WINDOW; cnt++) begin
      if (cnt == 13) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got=%h exp=0", result); end
        checks++; if (exception !== 1'b0) begin errors++; $display("FAIL rst_mid_exception got=%b exp=0", exception); end
        checks++; if (tag_out !== 5'd0) begin errors++; $display("FAIL rst_mid_tag got=%0d exp=0", tag_out); end
      end
      reset = (cnt == 12);
      if (result_valid === 1'b1) pulses++;
      @(posedge clock); #1;
    end
    reset = 1'b0;
    checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_pulses got=%0d exp=0", pulses); end

    run_op(1'b1, 32'd100, 32'd7, 5'd13, lat, res, exc, tg, pulses);
    checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL div100_7_latency got=%0d exp=%0d", lat, FULL_LAT); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL div100_7_result got=%0d exp=14", res); end
    checks++; if (exc !== 1'b0) begin errors++; $display("FAIL div100_7_exception got=%b exp=0", exc); end
    checks++; if (tg !== 5'd13) begin errors++; $display("FAIL div100_7_tag got=%0d exp=13", tg); end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
